// File: rtl/reg_writeback_unit.sv
// Register-file write side: merges load and ALU results through a small FIFO,
// drains one write per cycle, and tracks per-register pending writes for decode.
module reg_writeback_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_issue_valid,
  input  logic [ADDR_W-1:0]             i_issue_dest,
  input  logic                          i_ld_valid,
  output logic                          o_ld_ready,
  input  logic [ADDR_W-1:0]             i_ld_dest,
  input  logic [DATA_W-1:0]             i_ld_data,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [ADDR_W-1:0]             i_alu_dest,
  input  logic [DATA_W-1:0]             i_alu_data,
  output logic                          o_write_en,
  output logic [ADDR_W-1:0]             o_write_add,
  output logic [DATA_W-1:0]             o_write_data,
  output logic [(1<<ADDR_W)-1:0]        o_busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_issue_err
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];

  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  alu_ptr;
  logic              write_en_reg;
  logic [ADDR_W-1:0] write_add_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic [NREG-1:0]   busy_reg, busy_next;
  logic              issue_err_reg, issue_err_next;

  logic              ld_push, alu_push, pop;
  logic [ENT_W-1:0]  head_entry;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;
  logic              issue_conflict;

  // Ready depends only on the registered count so it never waits on the pop path.
  assign o_ld_ready  = (count_reg <= CNT_W'(FIFO_DEPTH - 1));
  assign o_alu_ready = (count_reg <= CNT_W'(FIFO_DEPTH - 2)) |
                       ((count_reg == CNT_W'(FIFO_DEPTH - 1)) & ~i_ld_valid);

  assign ld_push  = i_ld_valid  & o_ld_ready;
  assign alu_push = i_alu_valid & o_alu_ready;
  assign pop      = (count_reg != '0);

  // The load entry is older, so it takes the first free slot.
  assign alu_ptr     = wr_ptr_reg + PTR_W'(ld_push);
  assign wr_ptr_next = wr_ptr_reg + PTR_W'(ld_push) + PTR_W'(alu_push);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign count_next  = count_reg + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);

  assign head_entry = mem[rd_ptr_reg];
  assign head_dest  = head_entry[ENT_W-1:DATA_W];
  assign head_data  = head_entry[DATA_W-1:0];

  // Pushes only ever target free slots, so they never collide with the head read.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      mem[wr_ptr_reg] <= {i_ld_dest, i_ld_data};
    end
    if (alu_push) begin
      mem[alu_ptr] <= {i_alu_dest, i_alu_data};
    end
  end

  // Per-register scoreboard: a same-edge set beats the clear from the popped write.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit       = i_issue_valid & (i_issue_dest == ADDR_W'(gi));
      assign clr_bit       = pop & (head_dest == ADDR_W'(gi));
      assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
    end
  endgenerate

  assign issue_conflict = i_issue_valid & busy_reg[i_issue_dest] &
                          ~(pop & (head_dest == i_issue_dest));
  assign issue_err_next = issue_err_reg | issue_conflict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      write_en_reg   <= 1'b0;
      write_add_reg  <= '0;
      write_data_reg <= '0;
      busy_reg       <= '0;
      issue_err_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      write_en_reg  <= pop;
      busy_reg      <= busy_next;
      issue_err_reg <= issue_err_next;
      if (pop) begin
        write_add_reg  <= head_dest;
        write_data_reg <= head_data;
      end
    end
  end

  assign o_write_en   = write_en_reg;
  assign o_write_add  = write_add_reg;
  assign o_write_data = write_data_reg;
  assign o_busy_mask  = busy_reg;
  assign o_fifo_count = count_reg;
  assign o_issue_err  = issue_err_reg;

endmodule
